// File: rtl/xor_accum.sv
// xor_accum: accumulates the bitwise XOR and parity of a framed word stream.
// Optional out_count port is enabled by defining XOR_ACCUM_COUNT_EN.
module xor_accum #(
    parameter int WIDTH      = 8,
    parameter int MAX_WORDS  = 16,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_xor,
    output logic             out_parity,
    output logic             out_overrun
`ifdef XOR_ACCUM_COUNT_EN
    ,
    output logic [$clog2(MAX_WORDS+1)-1:0] out_count
`endif
);

    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);
    localparam logic [CW-1:0] ONE     = CW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] acc_q,     acc_d;
    logic [CW-1:0]    count_q,   count_d;
    logic             overrun_q, overrun_d;
    logic             parity_q,  parity_d;
    logic             beat;

    // Reset is folded into in_ready so no beat is reported while rst is high.
    assign in_ready = !rst && (state_q != S_HOLD);
    assign beat     = in_valid && in_ready;

    always_comb begin
        // NOTE: every signal gets a hold-value default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        acc_d     = acc_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (beat) begin
                    acc_d     = in_data;
                    count_d   = ONE;
                    overrun_d = 1'b0;
                    state_d   = in_last ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (beat) begin
                    acc_d   = acc_q ^ in_data;
                    count_d = count_q + ONE;
                    if (in_last) begin
                        overrun_d = 1'b0;
                        state_d   = S_HOLD;
                    end else if (count_d == MAX_CNT) begin
                        overrun_d = 1'b1;
                        state_d   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        parity_d = (^acc_d) ^ ODD_PARITY;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            parity_q  <= ODD_PARITY;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            parity_q  <= parity_d;
        end
    end

    assign out_valid   = (state_q == S_HOLD);
    assign out_xor     = acc_q;
    assign out_parity  = parity_q;
    assign out_overrun = overrun_q;
`ifdef XOR_ACCUM_COUNT_EN
    assign out_count   = count_q;
`endif

endmodule

// File: doc/xor_accum.md
XOR_ACCUM -- requirements
Module: xor_accum

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data word width in bits (1..64).
REQ-002 The block SHALL have parameter MAX_WORDS, default 16, giving the maximum words per frame (2..256).
REQ-003 The block SHALL have parameter ODD_PARITY, default 0: 0 selects even parity, 1 selects odd parity.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the input word is present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts an input word this cycle.
REQ-008 The block SHALL have port in_data, input, WIDTH bits: the input word.
REQ-009 The block SHALL have port in_last, input, 1 bit: the word is the final word of the frame.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a frame result is held.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port out_xor, output, WIDTH bits: the bitwise XOR of all words in the frame.
REQ-013 The block SHALL have port out_parity, output, 1 bit: the reduction XOR of out_xor, XORed with ODD_PARITY.
REQ-014 The block SHALL have port out_overrun, output, 1 bit: the frame was force-closed at MAX_WORDS without in_last.
REQ-015 The block SHALL have port out_count, output, clog2(MAX_WORDS+1) bits: the words in the frame; this port is present only per REQ-031.

Function
REQ-016 Beat acceptance SHALL be defined as in_valid and in_ready high at a rising clk edge; no word SHALL be accepted otherwise.
REQ-017 The FSM SHALL have three states, IDLE, ACCUM and HOLD, with in_ready=1 in IDLE and ACCUM and in_ready=0 in HOLD.
REQ-018 On a beat in IDLE, the block SHALL set acc=in_data and count=1, then go to HOLD if in_last is high, else to ACCUM.
REQ-019 On a beat in ACCUM, the block SHALL set acc=acc^in_data and count=count+1, then go to HOLD if in_last is high or the new count equals MAX_WORDS.
REQ-020 On entering HOLD at count==MAX_WORDS with in_last low, the block SHALL set overrun=1; on any other entry to HOLD it SHALL set overrun=0.
REQ-021 In HOLD, out_valid SHALL be 1, and out_xor, out_parity, out_overrun and out_count SHALL be registered and stable until the result is taken.
REQ-022 In HOLD with out_ready=1, the block SHALL go to IDLE on that edge, with out_valid low on the next cycle and no input accepted on that same edge.
REQ-023 Latency SHALL be one cycle: out_valid rises on the edge that accepts the closing word.
REQ-024 Outside HOLD, out_valid SHALL be 0; out_xor and the other results are don't-care but driven, and verification SHALL not check them.
REQ-025 A single-word frame (in_last on the first word) SHALL yield out_xor=in_data, count=1 and overrun=0.
REQ-026 In_valid deasserted mid-frame SHALL hold the current state and acc, with no timeout.
REQ-027 Wrap-around: count SHALL never exceed MAX_WORDS, and a beat carrying in_last at count MAX_WORDS SHALL close with overrun=0.

Reset
REQ-028 Asserting rst SHALL force, without waiting for clk, the state to IDLE, acc=0, count=0 and overrun=0, with outputs in_ready=0 while rst is high, out_valid=0, out_xor=0, out_parity=ODD_PARITY, out_overrun=0 and out_count=0.
REQ-029 A reset asserted mid-frame or in HOLD SHALL discard the partial or held result, so that no out_valid occurs for that frame.
REQ-030 After rst deasserts, in_ready SHALL be 1 from the first clk edge.

Configuration
REQ-031 When macro XOR_ACCUM_COUNT_EN is defined, the out_count port SHALL exist and report count; when it is undefined, the port SHALL be absent, the internal counter SHALL still limit frames at MAX_WORDS, and all other behaviour SHALL be identical.

Verification
REQ-032 The bench SHALL check: with WIDTH=8, a frame 0x0F, 0xF0, 0x3C (last) -> out_valid one cycle after the 0x3C edge, out_xor=0xC3, out_parity=0, out_overrun=0, count=3.
REQ-033 The bench SHALL check: with MAX_WORDS=4, words 0x01, 0x02, 0x04, 0x08 without in_last -> closes at the 4th beat, out_xor=0x0F, out_overrun=1, in_ready=0 until out_ready.
REQ-034 The bench SHALL check: a HOLD with out_ready low for 5 cycles and in_valid high -> outputs stable, no beat accepted, and after out_ready the next frame starts clean.
REQ-035 The bench SHALL check: rst pulsed after the 2nd word of a 3-word frame -> out_valid never rises for it, and a subsequent single word 0xA5 (last) -> out_xor=0xA5, out_parity=0 (1 when ODD_PARITY=1).
REQ-036 The bench SHALL check: in_valid toggled randomly over 10 words with WIDTH=16 -> out_xor equals the XOR of the accepted words only, and runs are made with XOR_ACCUM_COUNT_EN both defined and undefined.
